// File: rtl/fivebit_capture_if.sv
`default_nettype none
// fivebit_capture_if: capture result handshake between the capture block and its consumer.
interface fivebit_capture_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] capture_out;
  logic             capture_valid;
  logic             capture_ack;

  modport master (
    output capture_out,
    output capture_valid,
    input  capture_ack
  );

  modport slave (
    input  capture_out,
    input  capture_valid,
    output capture_ack
  );
endinterface
`default_nettype wire

// File: rtl/fivebit_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fivebit_capture: synchronised event input, interval capture via handshake |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fivebit_capture #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  event_in,
  input  logic                  arm,
  input  logic                  disarm,
  fivebit_capture_if.master     cap,
  output logic                  overflow,
  output logic                  lost,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic [WIDTH-1:0]       cap_q, cap_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   lost_q, lost_d;
  logic                   ev;

  assign ev = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      count_q <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      count_q <= count_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], event_in};
    hist_d  = sync_q[SYNC_STAGES-1];
    state_d = state_q;
    count_d = count_q;
    cap_d   = cap_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    lost_d  = lost_q;

    if (valid_q && cap.capture_ack) begin
      valid_d = 1'b0;
    end

    // State commands take priority and swallow any coincident event.
    if (disarm) begin
      state_d = IDLE;
      count_d = '0;
    end else if (arm) begin
      state_d = WAIT_FIRST;
      count_d = '0;
      ovf_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (ev) begin
            count_d = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (ev) begin
            cap_d   = count_q;
            valid_d = 1'b1;
            count_d = CNT_ONE;
            if (valid_q && !cap.capture_ack) begin
              lost_d = 1'b1;
            end
          end else if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: begin
          count_d = '0;
        end
      endcase
    end
  end

  assign cap.capture_out   = cap_q;
  assign cap.capture_valid = valid_q;
  assign overflow          = ovf_q;
  assign lost              = lost_q;
  assign busy              = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fivebit_capture.sv
`default_nettype none
// tb_fivebit_capture: scoreboard-driven bench for the interval capture block.
module tb_fivebit_capture;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic event_in = 1'b0;
  logic arm = 1'b0;
  logic disarm = 1'b0;
  logic ack_auto = 1'b0;
  logic ack_man = 1'b0;
  logic auto_ack = 1'b0;
  logic overflow, lost, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fivebit_capture_if #(.WIDTH(5)) cap_if ();
  assign cap_if.capture_ack = ack_auto | ack_man;

  fivebit_capture #(.WIDTH(5), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .event_in (event_in),
    .arm      (arm),
    .disarm   (disarm),
    .cap      (cap_if.master),
    .overflow (overflow),
    .lost     (lost),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  // Rising edge now, next rising edge due 'gap' cycles later.
  task automatic raise(input int gap);
    event_in = 1'b1;
    tick(1);
    event_in = 1'b0;
    tick(gap - 1);
  endtask

  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, cap_if.capture_out, e);
    end
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    tick(2);
    check_eq({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // Consumer: accept every capture while auto-ack is enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && cap_if.capture_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_capture", cap_if.capture_valid, 0);
        end else begin
          pop_check("auto_capture");
        end
        ack_auto = 1'b1;
        @(posedge clk);
        #1;
        ack_auto = 1'b0;
      end
    end
  end

  initial begin
    int guard;

    // Reset state
    tick(3);
    check_eq("rst_out",   cap_if.capture_out, 0);
    check_eq("rst_valid", cap_if.capture_valid, 0);
    check_eq("rst_ovf",   overflow, 0);
    check_eq("rst_lost",  lost, 0);
    check_eq("rst_busy",  busy, 0);
    rst = 1'b1;
    tick(2);

    // Back-to-back intervals of 10 with prompt consumer
    auto_ack = 1'b1;
    pulse_arm();
    check_eq("t1_busy", busy, 1);
    exp_q.push_back(10);
    exp_q.push_back(10);
    raise(10); raise(10); raise(10);
    wait_drain("t1");
    check_eq("t1_ovf",  overflow, 0);
    check_eq("t1_lost", lost, 0);

    // Saturation at 31, then a short interval, then re-arm clears overflow
    pulse_arm();
    exp_q.push_back(31);
    exp_q.push_back(5);
    raise(40); raise(5); raise(5);
    wait_drain("t2");
    check_eq("t2_ovf_sticky", overflow, 1);
    pulse_arm();
    check_eq("t2_ovf_clr", overflow, 0);

    // Unconsumed captures overwrite and set lost
    auto_ack = 1'b0;
    pulse_arm();
    exp_q.push_back(6);
    exp_q.push_back(6);
    raise(6);
    event_in = 1'b1; tick(1); event_in = 1'b0; tick(3);
    check_eq("t3_valid1", cap_if.capture_valid, 1);
    check_eq("t3_lost1",  lost, 0);
    pop_check("t3_cap1");
    tick(2);
    event_in = 1'b1; tick(1); event_in = 1'b0; tick(3);
    check_eq("t3_valid2", cap_if.capture_valid, 1);
    check_eq("t3_lost2",  lost, 1);
    pop_check("t3_cap2");
    pulse_arm();
    check_eq("t3_arm_lost", lost, 0);
    check_eq("t3_arm_valid", cap_if.capture_valid, 1);
    exp_q.push_back(7);
    raise(7);
    event_in = 1'b1; tick(1); event_in = 1'b0; tick(1);
    ack_man = 1'b1;
    tick(1);
    ack_man = 1'b0;
    check_eq("t3_ackcap_valid", cap_if.capture_valid, 1);
    check_eq("t3_ackcap_lost",  lost, 0);
    pop_check("t3_ackcap_val");
    ack_man = 1'b1;
    tick(1);
    ack_man = 1'b0;
    check_eq("t3_ack_clr", cap_if.capture_valid, 0);

    // Held-high event yields a single edge
    auto_ack = 1'b1;
    pulse_arm();
    event_in = 1'b1;
    tick(50);
    check_eq("t4_no_capture", cap_if.capture_valid, 0);
    check_eq("t4_ovf", overflow, 1);
    event_in = 1'b0;
    tick(3);
    exp_q.push_back(31);
    raise(5);
    wait_drain("t4");

    // arm+disarm together: disarm wins; IDLE ignores events
    pulse_arm();
    raise(5);
    tick(3);
    check_eq("t5_busy_pre", busy, 1);
    arm = 1'b1; disarm = 1'b1;
    tick(1);
    arm = 1'b0; disarm = 1'b0;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_count", dut.count_q, 0);
    raise(4); raise(4); raise(4);
    tick(6);
    check_eq("t5_idle_valid", cap_if.capture_valid, 0);

    // Asynchronous reset mid-interval
    auto_ack = 1'b0;
    pulse_arm();
    exp_q.push_back(4);
    raise(4); raise(4);
    check_eq("t6_valid", cap_if.capture_valid, 1);
    pop_check("t6_cap");
    guard = 0;
    while (dut.count_q != 5'd17 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_eq("t6_count17", dut.count_q, 17);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_out",   cap_if.capture_out, 0);
    check_eq("t6_rst_valid", cap_if.capture_valid, 0);
    check_eq("t6_rst_ovf",   overflow, 0);
    check_eq("t6_rst_lost",  lost, 0);
    check_eq("t6_rst_busy",  busy, 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    auto_ack = 1'b1;
    pulse_arm();
    exp_q.push_back(3);
    raise(3); raise(3);
    wait_drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
